// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: default bit timing and the receiver state encoding.
package rs232_pkg;

  localparam int unsigned RS232_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rs232_state_e;

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input with a selectable reset level.
module rs232_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 serial receiver: mid-bit sampling, glitch rejection on the start bit, framing-error
// detection and break handling. Output byte is held until the next good frame.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = RS232_CLKS_PER_BIT
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] RS_DATAOUT,
  output logic       RS_DONE,
  output logic       RS_FRAME_ERR,
  output logic       RS_BUSY
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic         w_rx;
  rs232_state_e r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]   r_bit_idx;
  logic [7:0]   r_shift;
  logic [7:0]   r_dataout;
  logic         r_done;
  logic         r_ferr;

  rs232_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk(CLK_50MHZ),
    .i_rst(RST),
    .i_d  (RXD),
    .o_q  (w_rx)
  );

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_dataout <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state   <= START;
            r_bit_cnt <= '0;
          end
        end
        START: begin
          // Start bit must still be low at its midpoint, otherwise it was a glitch.
          if (r_bit_cnt == CNT_HALF) begin
            r_bit_cnt <= '0;
            if (!w_rx) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_bit_cnt == CNT_LAST) begin
            r_bit_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit of slack to catch a back-to-back start.
          if (r_bit_cnt == CNT_LAST) begin
            r_bit_cnt <= '0;
            if (w_rx) begin
              r_dataout <= r_shift;
              r_done    <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        BREAK: begin
          if (w_rx) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign RS_DATAOUT   = r_dataout;
  assign RS_DONE      = r_done;
  assign RS_FRAME_ERR = r_ferr;
  assign RS_BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// Scoreboard bench for rs232_rx: the driver serialises frames and queues the expected pulse,
// a negedge monitor pops and compares each DONE/FRAME_ERR pulse (kind, byte, cycle).
module tb_rs232_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
  logic       busy;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  rs232_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK_50MHZ   (clk),
    .RST         (rst),
    .RXD         (rxd),
    .RS_DATAOUT  (dout),
    .RS_DONE     (done),
    .RS_FRAME_ERR(ferr),
    .RS_BUSY     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a good stop bit delivers the byte; a bad one flags an error
  // and leaves the last good byte on the output. Pulse lands 155 edges after the call.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int hc);
    exp_t e;
    e.is_ferr = !stop;
    e.data    = stop ? d : last_good;
    e.cyc     = (hc == 32) ? cyc + 2 + HALF + 9 * CPB + 1 : -1;
    if (stop) last_good = d;
    q.push_back(e);
    rxd = 1'b0;
    #(hc * 5);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(hc * 5);
    end
    rxd = stop;
    #(hc * 5);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) #10;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done || ferr) begin
      chk("done_ferr_exclusive", int'(done && ferr), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_is_ferr", int'(ferr), int'(mon_e.is_ferr));
        chk("rs_dataout", int'(dout), int'(mon_e.data));
        if (mon_e.cyc >= 0) chk("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int n;
    logic [7:0] d;
    bit stop;
    logic [7:0] c5;

    #1 rst = 1'b1;
    #1;
    chk("reset_dataout", int'(dout), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);

    // Single frame with exact latency and busy window
    align();
    n = cyc;
    fork
      send_frame(8'h55, 1'b1, 32);
      begin
        wait_cyc(n + 2);
        chk("busy_before_start", int'(busy), 0);
        wait_cyc(n + 4);
        chk("busy_start", int'(busy), 1);
        wait_cyc(n + 154);
        chk("busy_stop", int'(busy), 1);
        wait_cyc(n + 155);
        chk("busy_after_done", int'(busy), 0);
        chk("done_at_latency", int'(done), 1);
      end
    join
    idle(20);

    // Back-to-back frames, one stop bit, no gap
    align();
    send_frame(8'hA3, 1'b1, 32);
    send_frame(8'h0F, 1'b1, 32);
    idle(20);

    // Start-bit glitch
    align();
    n = cyc;
    rxd = 1'b0;
    #40;
    rxd = 1'b1;
    wait_cyc(n + 1 + 1 + HALF);
    chk("glitch_busy_high", int'(busy), 1);
    wait_cyc(n + 2 + 1 + HALF);
    chk("glitch_busy_fall", int'(busy), 0);
    idle(20);
    align();
    send_frame(8'h81, 1'b1, 32);
    idle(20);

    // Framing error followed by a held-low line
    align();
    send_frame(8'hFF, 1'b0, 32);
    rxd = 1'b0;
    repeat (40) #10;
    chk("break_busy", int'(busy), 1);
    chk("break_dataout_held", int'(dout), 'h81);
    rxd = 1'b1;
    repeat (5) #10;
    chk("break_exit_busy", int'(busy), 0);
    idle(20);
    align();
    send_frame(8'h3C, 1'b1, 32);
    idle(20);

    // Asynchronous reset during data bit 3
    align();
    c5 = 8'hC5;
    rxd = 1'b0;
    #160;
    for (int i = 0; i < 3; i++) begin
      rxd = c5[i];
      #160;
    end
    rxd = c5[3];
    #80;
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    #2;
    chk("async_rst_dataout", int'(dout), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_ferr", int'(ferr), 0);
    chk("async_rst_busy", int'(busy), 0);
    rxd = 1'b1;
    repeat (3) #10;
    rst = 1'b0;
    last_good = 8'h00;
    idle(300);
    chk("post_reset_dataout", int'(dout), 0);
    align();
    send_frame(8'h3C, 1'b1, 32);
    idle(20);

    // Transmitter 3% slow
    align();
    send_frame(8'h00, 1'b1, 33);
    send_frame(8'hFF, 1'b1, 33);
    send_frame(8'h6B, 1'b1, 33);
    idle(20);

    // Random frames, occasional bad stop bit
    for (int k = 0; k < 12; k++) begin
      align();
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, 32);
      if (stop) idle(int'($urandom_range(0, 10)));
      else idle(int'($urandom_range(4, 20)));
    end
    idle(40);

    for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
